pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath. It replaces the fixed per-stage registers between fetch/decode/exec/memory/writeback with one generic block. It is data-width generic, has a valid/ready handshake on both sides, stall and flush inputs from the hazard unit, and an optional two-entry skid buffer. The skid buffer lets `in_ready` be driven from registers, so no combinational ready path crosses the stage.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_stage_buf_if.sv | 22 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_buf.sv | 106 ++++++++++
 tb/tb_pipe_stage_buf.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the generic pipeline stage buffer.
package pipe_pkg;

    // Number of entries held by a stage (0..2).
    typedef logic [1:0] occ_t;

    // Capacity of a stage when the skid slot is built.
    localparam int PIPE_MAX_OCC = 2;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready handshake on both sides of a pipeline stage.
// The slave modport is the stage's view; master is the surrounding datapath.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one valid + payload register. Priority: reset > clear > load.
// Clear drops the valid bit only; the payload keeps its last value.
module pipe_slot #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state selection for the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (ld_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with valid/ready handshake,
// hazard stall/flush and an optional skid slot.
// Build option: define PIPE_STAGE_SKID_EN to add the second (skid) entry so
// that in_ready is a pure function of registers and the hazard inputs.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    pipe_stage_buf_if.slave        bus,
    output occ_t                   occupancy
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ld, m_clr;
    logic [DATA_W-1:0] m_d;

    logic              out_valid, in_ready;
    logic              in_fire, out_fire;

    // A frozen or flushed stage never presents or accepts anything, so the
    // fire terms below are already zero during stall/flush.
    assign out_valid = m_valid & ~stall & ~flush;
    assign out_fire  = out_valid & bus.out_ready;
    assign in_fire   = bus.in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ld, s_clr;

    // Ready only looks at the skid valid: no path from out_ready to in_ready.
    assign in_ready = ~s_valid & ~stall & ~flush;

    // Slot control: skid drains into main first so ordering is preserved;
    // a new entry goes to main when main is free or leaving, else to skid.
    always_comb begin
        m_ld  = 1'b0;
        m_clr = flush;
        m_d   = bus.in_data;
        s_ld  = 1'b0;
        s_clr = flush;
        if (out_fire && s_valid) begin
            m_ld  = 1'b1;
            m_d   = s_data;
            s_clr = 1'b1;
        end else if (in_fire && (!m_valid || out_fire)) begin
            m_ld  = 1'b1;
        end else if (in_fire) begin
            s_ld  = 1'b1;
        end else if (out_fire) begin
            m_clr = 1'b1;
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (s_clr),
        .ld_i    (s_ld),
        .d_i     (bus.in_data),
        .valid_o (s_valid),
        .data_o  (s_data)
    );

    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
    // Single-entry stage: can take a new payload when empty or draining this
    // cycle, which makes in_ready combinational in out_ready.
    assign in_ready = (~m_valid | bus.out_ready) & ~stall & ~flush;

    // Slot control: load on accept, drop when the entry leaves with no refill.
    always_comb begin
        m_ld  = in_fire;
        m_clr = flush | (out_fire & ~in_fire);
        m_d   = bus.in_data;
    end

    assign occupancy = {1'b0, m_valid};
`endif

    pipe_slot #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (m_clr),
        .ld_i    (m_ld),
        .d_i     (m_d),
        .valid_o (m_valid),
        .data_o  (m_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = m_data;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf; expectations adapt
// to the PIPE_STAGE_SKID_EN build option.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int              DW      = 32;
    localparam logic [DW-1:0]   RST_VAL = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset, stall, flush;
    occ_t occupancy;

    pipe_stage_buf_if #(.DATA_W(DW)) bus ();

    pipe_stage_buf #(
        .DATA_W     (DW),
        .RESET_DATA (RST_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sb[$];     // expected stage contents, oldest first
    logic [DW-1:0] outs[$];   // payloads delivered downstream
    logic          mon_en = 1'b0;
    logic          e_in_fire = 1'b0, e_out_fire = 1'b0, last_acc = 1'b0;
    logic [DW-1:0] e_in_data = '0;

    // Scoreboard monitor: check handshake outputs every cycle, pop on delivery.
    always @(negedge clk) begin
        logic e_ov, e_ir;
        if (mon_en) begin
            e_ov = (sb.size() > 0) && !stall && !flush;
`ifdef PIPE_STAGE_SKID_EN
            e_ir = (sb.size() < 2) && !stall && !flush;
`else
            e_ir = ((sb.size() == 0) || bus.out_ready) && !stall && !flush;
`endif
            n_vec++;
            if (bus.out_valid !== e_ov) begin
                n_err++;
                $display("FAIL mon_out_valid t=%0t got=%b want=%b", $time, bus.out_valid, e_ov);
            end
            n_vec++;
            if (bus.in_ready !== e_ir) begin
                n_err++;
                $display("FAIL mon_in_ready t=%0t got=%b want=%b", $time, bus.in_ready, e_ir);
            end
            n_vec++;
            if (occupancy !== occ_t'(sb.size())) begin
                n_err++;
                $display("FAIL mon_occupancy t=%0t got=%0d want=%0d", $time, occupancy, sb.size());
            end
            if (e_ov && bus.out_ready) begin
                n_vec++;
                if (bus.out_data !== sb[0]) begin
                    n_err++;
                    $display("FAIL mon_out_data t=%0t got=%h want=%h", $time, bus.out_data, sb[0]);
                end
                outs.push_back(bus.out_data);
            end
            e_in_fire  = bus.in_valid && e_ir;
            e_out_fire = e_ov && bus.out_ready;
            e_in_data  = bus.in_data;
            last_acc   = e_in_fire;
        end
    end

    // Reference model state update on the clock edge.
    always @(posedge clk) begin
        if (mon_en) begin
            if (reset || flush) begin
                sb.delete();
            end else if (!stall) begin
                if (e_out_fire) void'(sb.pop_front());
                if (e_in_fire)  sb.push_back(e_in_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        cyc(); cyc();
        mon_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || bus.out_data !== RST_VAL || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state ov=%b occ=%0d data=%h ir=%b want ov=0 occ=0 data=%h ir=1",
                     bus.out_valid, occupancy, bus.out_data, bus.in_ready, RST_VAL);
        end
    endtask

    task automatic test_first();
        cyc();
        bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678; bus.out_ready = 1'b1;
        @(negedge clk);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL first_latency ov=%b data=%h occ=%0d want ov=1 data=12345678 occ=1",
                     bus.out_valid, bus.out_data, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        cyc();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            @(negedge clk);
            if (i > 1) begin
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i - 1)) begin
                    n_err++;
                    $display("FAIL stream_%0d ov=%b data=%h want ov=1 data=%h",
                             i - 1, bus.out_valid, bus.out_data, DW'(i - 1));
                end
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8) begin
            n_err++;
            $display("FAIL stream_8 ov=%b data=%h want ov=1 data=8", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_skid();
        logic [DW-1:0] want[$];
        bit            acc;
        cyc();
        outs.delete();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hA;
        @(negedge clk); cyc();
        bus.in_data = 32'hB;
        @(negedge clk); cyc();
        bus.in_data = 32'hC;
        @(negedge clk);
        n_vec++;
        if (occupancy !== occ_t'(CAP) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hA) begin
            n_err++;
            $display("FAIL skid_full occ=%0d ir=%b ov=%b data=%h want occ=%0d ir=0 ov=1 data=a",
                     occupancy, bus.in_ready, bus.out_valid, bus.out_data, CAP);
        end
        cyc();
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            cyc();
            acc = last_acc;
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL skid_accept_c got=not_accepted want=accepted");
        end
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        n_vec++;
        if (occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL skid_drain occ=%0d want=0", occupancy);
        end
`ifdef PIPE_STAGE_SKID_EN
        want = '{32'hA, 32'hB, 32'hC};
`else
        want = '{32'hA, 32'hC};
`endif
        n_vec++;
        if (outs.size() != want.size()) begin
            n_err++;
            $display("FAIL skid_count got=%0d want=%0d", outs.size(), want.size());
        end else begin
            for (int k = 0; k < want.size(); k++) begin
                n_vec++;
                if (outs[k] !== want[k]) begin
                    n_err++;
                    $display("FAIL skid_order_%0d got=%h want=%h", k, outs[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_flush_stall();
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h11;
        @(negedge clk); cyc();
        bus.in_data = 32'h22;
        @(negedge clk); cyc();
        bus.in_data = 32'h33; flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        n_vec++;
        if (occupancy !== occ_t'(CAP) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle occ=%0d ov=%b ir=%b want occ=%0d ov=0 ir=0",
                     occupancy, bus.out_valid, bus.in_ready, CAP);
        end
        cyc();
        flush = 1'b0; stall = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after occ=%0d ov=%b want occ=0 ov=0", occupancy, bus.out_valid);
        end
    endtask

    task automatic test_stall();
        cyc();
        outs.delete();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h44;
        @(negedge clk); cyc();
        bus.in_data = 32'h55; stall = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (occupancy !== 2'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold_%0d occ=%0d ov=%b ir=%b want occ=1 ov=0 ir=0",
                         k, occupancy, bus.out_valid, bus.in_ready);
            end
            cyc();
        end
        stall = 1'b0;
        @(negedge clk); cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        n_vec++;
        if (outs.size() != 2) begin
            n_err++;
            $display("FAIL stall_count got=%0d want=2", outs.size());
        end else begin
            n_vec++;
            if (outs[0] !== 32'h44 || outs[1] !== 32'h55) begin
                n_err++;
                $display("FAIL stall_order got=%h,%h want=44,55", outs[0], outs[1]);
            end
        end
    endtask

    task automatic test_reset_full();
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h66;
        @(negedge clk); cyc();
        bus.in_data = 32'h77;
        @(negedge clk); cyc();
        bus.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (occupancy !== occ_t'(CAP)) begin
            n_err++;
            $display("FAIL rstfull_pre occ=%0d want=%0d", occupancy, CAP);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== RST_VAL || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL rstfull_post ov=%b data=%h occ=%0d want ov=0 data=%h occ=0",
                     bus.out_valid, bus.out_data, occupancy, RST_VAL);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 9) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        cyc();
        bus.in_valid = 1'b0; stall = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        n_vec++;
        if (occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL random_drain occ=%0d want=0", occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_back_to_back();
        test_skid();
        test_flush_stall();
        test_stall();
        test_reset_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
